// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clk_en_gen clock-enable generator.
package clk_en_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    RUN
  } state_t;

  localparam int LOSS_CNT_W = 8;
  // Widest divide ratio the helper below accepts.
  localparam int RATIO_W    = 16;

  // A programmed ratio of 0 behaves exactly like a ratio of 1.
  function automatic logic [RATIO_W-1:0] eff_ratio(input logic [RATIO_W-1:0] n);
    return (n == '0) ? RATIO_W'(1) : n;
  endfunction

endpackage

// File: rtl/clk_en_div_ch.sv
// One divider channel: period counter, active/pending ratio and the
// registered ce pulse / clk_div square wave.
module clk_en_div_ch
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  input  logic [DIV_W-1:0] init_val,
  output logic             ce,
  output logic             clk_div
);

  localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

  logic             running_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] pending;
  logic [DIV_W:0]   n_act;
  logic [DIV_W:0]   n_use;
  logic [DIV_W:0]   half_use;
  logic [DIV_W-1:0] cnt_d;
  logic             load;

  // A period starts on entry to RUN and on every wrap; that is the only
  // point where a pending ratio may take over.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch.
    n_act    = (DIV_W+1)'(eff_ratio(RATIO_W'(active)));
    load     = !running_q || ({1'b0, cnt} == n_act - ONE);
    n_use    = n_act;
    cnt_d    = cnt + 1'b1;
    if (load) begin
      n_use = (DIV_W+1)'(eff_ratio(RATIO_W'(pending)));
      cnt_d = '0;
    end
    half_use = (n_use + ONE) >> 1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the ratio registers are reset too, so a restart always begins
      // from the init ratios and any pending write is dropped.
      running_q <= 1'b0;
      cnt       <= '0;
      active    <= init_val;
      pending   <= init_val;
      ce        <= 1'b0;
      clk_div   <= 1'b0;
    end else begin
      running_q <= run;
      if (wr) pending <= wr_val;
      if (!run) begin
        cnt     <= '0;
        active  <= pending;
        ce      <= 1'b0;
        clk_div <= 1'b0;
      end else begin
        cnt     <= cnt_d;
        if (load) active <= pending;
        ce      <= ({1'b0, cnt_d} == n_use - ONE);
        clk_div <= ({1'b0, cnt_d} < half_use);
      end
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Lock-qualified clock-enable generator: lock synchroniser, lock FSM and
// NUM_CH divider channels. Define CLK_EN_GEN_LOSS_CNT_EN to add loss_cnt.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int                       NUM_CH      = 2,
  parameter int                       DIV_W       = 8,
  parameter int                       LOCK_STABLE = 16,
  parameter logic [NUM_CH*DIV_W-1:0]  DIV_INIT    = {8'd4, 8'd10},
  localparam int                      SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              lost_clr,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_div,
  output logic              ready,
  output logic              lock_lost
`ifdef CLK_EN_GEN_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

  localparam int STAB_W = $clog2(LOCK_STABLE + 1);

  logic [1:0]        sync_q;
  logic              lock_s;
  state_t            state, state_d;
  logic [STAB_W-1:0] stab, stab_d;
  logic              set_lost;
  logic              run;

  assign lock_s = sync_q[1];
  assign run    = (state_d == RUN);

  always_comb begin
    state_d  = state;
    stab_d   = stab;
    set_lost = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
          stab_d  = STAB_W'(1);
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else begin
          stab_d = stab + 1'b1;
          if (stab >= STAB_W'(LOCK_STABLE - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          stab_d   = '0;
          set_lost = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        stab_d  = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state     <= WAIT_LOCK;
      stab      <= '0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pll_locked};
      state     <= state_d;
      stab      <= stab_d;
      ready     <= run;
      // A new loss outranks a simultaneous clear.
      if (set_lost)      lock_lost <= 1'b1;
      else if (lost_clr) lock_lost <= 1'b0;
    end
  end

`ifdef CLK_EN_GEN_LOSS_CNT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (lost_clr) begin
      loss_cnt <= set_lost ? LOSS_CNT_W'(1) : '0;
    end else if (set_lost && (loss_cnt != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end
`endif

  // div_sel values with no matching channel decode to no write at all.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_div_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .run      (run),
      .wr       (div_we && (div_sel == SEL_W'(g))),
      .wr_val   (div_val),
      .init_val (DIV_INIT[g*DIV_W +: DIV_W]),
      .ce       (ce[g]),
      .clk_div  (clk_div[g])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen against a cycle-level behavioural model
// (lock streak counting, per-channel period position, pending ratios).
module tb_clk_en_gen;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_STABLE = 16;
  localparam int SEL_W       = 2;
  localparam logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd7, 8'd4, 8'd10};
  localparam int VW          = 2 + 2*NUM_CH;

  logic              refclk     = 1'b0;
  logic              rst_n      = 1'b0;
  logic              pll_locked = 1'b0;
  logic              div_we     = 1'b0;
  logic [SEL_W-1:0]  div_sel    = '0;
  logic [DIV_W-1:0]  div_val    = '0;
  logic              lost_clr   = 1'b0;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] clk_div;
  logic              ready;
  logic              lock_lost;
`ifdef CLK_EN_GEN_LOSS_CNT_EN
  logic [7:0]        loss_cnt;
`endif
  logic [VW-1:0]     dut_vec;

  assign dut_vec = {ready, lock_lost, ce, clk_div};

  always #5 refclk = ~refclk;

  clk_en_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_STABLE (LOCK_STABLE),
    .DIV_INIT    (DIV_INIT)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .div_we     (div_we),
    .div_sel    (div_sel),
    .div_val    (div_val),
    .lost_clr   (lost_clr),
    .ce         (ce),
    .clk_div    (clk_div),
    .ready      (ready),
    .lock_lost  (lock_lost)
`ifdef CLK_EN_GEN_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  // Behavioural model state
  int m_pos [NUM_CH];
  int m_n   [NUM_CH];
  int m_pend[NUM_CH];
  int streak;
  bit m_run;
  bit m_lost;
  int m_loss;
  bit dly[$];
  int edge_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int eff(int n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int init_ratio(int i);
    logic [NUM_CH*DIV_W-1:0] v;
    v = DIV_INIT;
    return int'(v[i*DIV_W +: DIV_W]);
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [NUM_CH-1:0] e_ce, e_div;
    for (int i = 0; i < NUM_CH; i++) begin
      e_ce[i]  = m_run && (m_pos[i] == m_n[i] - 1);
      e_div[i] = m_run && (m_pos[i] < (m_n[i] + 1) / 2);
    end
    return {m_run, m_lost, e_ce, e_div};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = init_ratio(i);
      m_pos[i]  = 0;
      m_n[i]    = 1;
    end
    streak = 0;
    m_run  = 1'b0;
    m_lost = 1'b0;
    m_loss = 0;
    dly.delete();
    dly.push_back(1'b0);
    dly.push_back(1'b0);
  endtask

  // RUN holds exactly while the synced lock has been high for LOCK_STABLE
  // or more consecutive samples; the synced sample lags pll_locked by 2.
  task automatic model_edge();
    bit ls, prev, set;
    ls = dly.pop_front();
    dly.push_back(pll_locked);
    prev   = m_run;
    streak = ls ? streak + 1 : 0;
    m_run  = (streak >= LOCK_STABLE);
    set    = prev && !m_run;
    if (set)           m_lost = 1'b1;
    else if (lost_clr) m_lost = 1'b0;
    if (lost_clr)                  m_loss = set ? 1 : 0;
    else if (set && m_loss < 255)  m_loss++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_run) begin
        if (!prev) begin
          m_pos[i] = 0;
          m_n[i]   = eff(m_pend[i]);
        end else begin
          m_pos[i]++;
          if (m_pos[i] == m_n[i]) begin
            m_pos[i] = 0;
            m_n[i]   = eff(m_pend[i]);
          end
        end
      end
    end
    if (div_we && int'(div_sel) < NUM_CH) m_pend[div_sel] = int'(div_val);
  endtask

  task automatic cycle();
    @(posedge refclk);
    edge_cnt++;
    model_edge();
    @(negedge refclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    if (dut_vec !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got %h want 0", dut_vec);
    end
    n_cmp++;
    model_reset();
    rst_n    = 1'b1;
    edge_cnt = 0;
    repeat (5) begin
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL reset_idle @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_lockup();
    int rise = -1;
    int first[NUM_CH];
    for (int i = 0; i < NUM_CH; i++) first[i] = -1;
    for (int k = 0; k < 60; k++) begin
      if (edge_cnt == 10) pll_locked = 1'b1;
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL lockup @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
      if (ready && rise < 0) rise = edge_cnt;
      for (int i = 0; i < NUM_CH; i++)
        if (rise >= 0 && ce[i] && first[i] < 0) first[i] = edge_cnt;
    end
    if (rise != 10 + 2 + LOCK_STABLE) begin
      n_bad++;
      $display("FAIL lockup_ready_edge: got %0d want %0d", rise, 10 + 2 + LOCK_STABLE);
    end
    n_cmp++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise < 0 || first[i] != rise + init_ratio(i) - 1) begin
        n_bad++;
        $display("FAIL lockup_first_ce%0d: got %0d want %0d", i, first[i], rise + init_ratio(i) - 1);
      end
      n_cmp++;
    end
  endtask

  task automatic test_lock_loss();
    int k;
    pll_locked = 1'b0;
    repeat (3) begin
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL loss_drop @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    if (ready !== 1'b0 || ce !== '0 || clk_div !== '0 || lock_lost !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_quiet: got %h want ready/ce/div=0 lock_lost=1", dut_vec);
    end
    n_cmp++;
    pll_locked = 1'b1;
    k = 0;
    while (!ready && k < 40) begin
      cycle();
      k++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL loss_relock @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    if (!ready) begin
      n_bad++;
      $display("FAIL loss_relock_timeout: ready=%b want 1", ready);
    end
    n_cmp++;
    repeat (25) begin
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL loss_restart @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    // Second loss with lost_clr on exactly the edge where the loss registers.
    pll_locked = 1'b0;
    cycle();
    cycle();
    lost_clr = 1'b1;
    cycle();
    lost_clr = 1'b0;
    if (lock_lost !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_set_beats_clr: lock_lost=%b ready=%b want 1/0", lock_lost, ready);
    end
    n_cmp++;
  endtask

  task automatic test_glitch();
    int k;
    int a1;
    int rise = -1;
    lost_clr = 1'b1;
    cycle();
    lost_clr = 1'b0;
    pll_locked = 1'b1;
    for (k = 0; k < 9; k++) begin
      if (k == 8) pll_locked = 1'b0;
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL glitch_pre @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    pll_locked = 1'b1;
    a1 = edge_cnt;
    k = 0;
    while (!ready && k < 40) begin
      cycle();
      k++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL glitch_relock @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    if (ready) rise = edge_cnt;
    if (rise != a1 + 2 + LOCK_STABLE || lock_lost !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_ready_edge: got %0d lost=%b want %0d lost=0", rise, lock_lost, a1 + 2 + LOCK_STABLE);
    end
    n_cmp++;
  endtask

  task automatic write_ratio(input int sel, input int val);
    div_sel = SEL_W'(sel);
    div_val = DIV_W'(val);
    div_we  = 1'b1;
    cycle();
    div_we  = 1'b0;
    if (dut_vec !== model_vec()) begin
      n_bad++;
      $display("FAIL write_cycle @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
    end
    n_cmp++;
  endtask

  task automatic test_ratio_change();
    int k;
    int t0;
    int t[$];
    k = 0;
    while (!ce[0] && k < 20) begin
      cycle();
      k++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL ratio_wait @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    t0 = edge_cnt;
    repeat (3) cycle();
    write_ratio(0, 3);
    repeat (25) begin
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL ratio_n3 @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
      if (ce[0]) t.push_back(edge_cnt);
    end
    if (t.size() < 3 || t[0] - t0 != 10 || t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
      n_bad++;
      $display("FAIL ratio_gaps: got %0d pulses, gaps %0d/%0d/%0d want 10/3/3", t.size(),
               (t.size() > 0) ? t[0] - t0 : -1, (t.size() > 1) ? t[1] - t[0] : -1,
               (t.size() > 2) ? t[2] - t[1] : -1);
    end
    n_cmp++;
    write_ratio(1, 0);
    repeat (6) cycle();
    write_ratio(0, 1);
    repeat (5) cycle();
    repeat (5) begin
      cycle();
      if (ce[1:0] !== 2'b11 || clk_div[1:0] !== 2'b11) begin
        n_bad++;
        $display("FAIL ratio_n01_const @%0d: ce=%b div=%b want 11/11", edge_cnt, ce[1:0], clk_div[1:0]);
      end
      n_cmp++;
    end
    write_ratio(3, 5);
    repeat (12) begin
      cycle();
      if (dut_vec !== model_vec() || ce[1:0] !== 2'b11) begin
        n_bad++;
        $display("FAIL ratio_bad_sel @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      div_we   = ($urandom_range(0, 3) == 0);
      div_sel  = SEL_W'($urandom_range(0, 3));
      div_val  = DIV_W'($urandom_range(0, 12));
      lost_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 79) == 0) pll_locked = ~pll_locked;
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL random @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    div_we   = 1'b0;
    lost_clr = 1'b0;
    pll_locked = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int k;
    int rise = -1;
    int first[NUM_CH];
    for (int i = 0; i < NUM_CH; i++) first[i] = -1;
    k = 0;
    while (!ready && k < 40) begin
      cycle();
      k++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL rst_prelock @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
    end
    write_ratio(0, 3);
    div_sel = SEL_W'(2);
    div_val = DIV_W'(2);
    div_we  = 1'b1;
    cycle();
    div_we  = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    if (dut_vec !== '0) begin
      n_bad++;
      $display("FAIL rst_async_clear: got %h want 0", dut_vec);
    end
    n_cmp++;
    model_reset();
    @(negedge refclk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    k = 0;
    while (rise < 0 && k < 40) begin
      cycle();
      k++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL rst_relock @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
      if (ready) rise = edge_cnt;
    end
    if (rise != 2 + LOCK_STABLE) begin
      n_bad++;
      $display("FAIL rst_ready_edge: got %0d want %0d", rise, 2 + LOCK_STABLE);
    end
    n_cmp++;
    repeat (12) begin
      cycle();
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL rst_restart @%0d: got %h want %h", edge_cnt, dut_vec, model_vec());
      end
      n_cmp++;
      for (int i = 0; i < NUM_CH; i++)
        if (ce[i] && first[i] < 0) first[i] = edge_cnt;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise < 0 || first[i] != rise + init_ratio(i) - 1) begin
        n_bad++;
        $display("FAIL rst_init_ratio%0d: first ce %0d want %0d", i, first[i], rise + init_ratio(i) - 1);
      end
      n_cmp++;
    end
  endtask

`ifdef CLK_EN_GEN_LOSS_CNT_EN
  task automatic test_loss_cnt();
    int k;
    lost_clr = 1'b1;
    cycle();
    lost_clr = 1'b0;
    for (int n = 0; n < 300; n++) begin
      pll_locked = 1'b1;
      k = 0;
      while (!ready && k < 40) begin
        cycle();
        k++;
      end
      pll_locked = 1'b0;
      k = 0;
      while (ready && k < 6) begin
        cycle();
        k++;
      end
      if (loss_cnt !== 8'(m_loss) || dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL loss_cnt_step %0d: got %0d want %0d", n, loss_cnt, m_loss);
      end
      n_cmp++;
    end
    if (loss_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL loss_cnt_saturate: got %0d want 255", loss_cnt);
    end
    n_cmp++;
    pll_locked = 1'b1;
    k = 0;
    while (!ready && k < 40) begin
      cycle();
      k++;
    end
    pll_locked = 1'b0;
    cycle();
    cycle();
    lost_clr = 1'b1;
    cycle();
    lost_clr = 1'b0;
    if (loss_cnt !== 8'd1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_cnt_clr_and_inc: got %0d ready=%b want 1/0", loss_cnt, ready);
    end
    n_cmp++;
  endtask
`endif

  initial begin
    model_reset();
    edge_cnt = 0;
    test_reset();
    test_lockup();
    test_lock_loss();
    test_glitch();
    test_ratio_change();
    test_random();
    test_reset_mid_run();
`ifdef CLK_EN_GEN_LOSS_CNT_EN
    test_loss_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
